// File: rtl/vadd_ctrl_pkg.sv
// Shared definitions for the vector-add dataflow sequencer: one-hot state
// encodings, their bit positions and the load-channel bound.
package vadd_ctrl_pkg;

    localparam int STATE_W      = 7;
    localparam int MAX_NUM_LOAD = 8;

    localparam int IDLE_IDX     = 0;
    localparam int LOAD_IDX     = 1;
    localparam int CP_ISSUE_IDX = 2;
    localparam int CP_WAIT_IDX  = 3;
    localparam int ST_ISSUE_IDX = 4;
    localparam int ST_WAIT_IDX  = 5;
    localparam int ZERO_IDX     = 6;

    localparam logic [STATE_W-1:0] IDLE_OH     = STATE_W'(1) << IDLE_IDX;
    localparam logic [STATE_W-1:0] LOAD_OH     = STATE_W'(1) << LOAD_IDX;
    localparam logic [STATE_W-1:0] CP_ISSUE_OH = STATE_W'(1) << CP_ISSUE_IDX;
    localparam logic [STATE_W-1:0] CP_WAIT_OH  = STATE_W'(1) << CP_WAIT_IDX;
    localparam logic [STATE_W-1:0] ST_ISSUE_OH = STATE_W'(1) << ST_ISSUE_IDX;
    localparam logic [STATE_W-1:0] ST_WAIT_OH  = STATE_W'(1) << ST_WAIT_IDX;
    localparam logic [STATE_W-1:0] ZERO_OH     = STATE_W'(1) << ZERO_IDX;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = IDLE_OH,
        S_LOAD     = LOAD_OH,
        S_CP_ISSUE = CP_ISSUE_OH,
        S_CP_WAIT  = CP_WAIT_OH,
        S_ST_ISSUE = ST_ISSUE_OH,
        S_ST_WAIT  = ST_WAIT_OH,
        S_ZERO     = ZERO_OH
    } state_t;

endpackage

// File: rtl/hls_start_reg.sv
// Start latch for one HLS-style sub-block: set wins over the ready-driven
// clear, so a start requested in the same cycle as ready is never lost.
module hls_start_reg (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic set,
    input  logic ap_ready,
    output logic ap_start
);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ap_start <= 1'b0;
        end else if (set) begin
            ap_start <= 1'b1;
        end else if (ap_ready) begin
            ap_start <= 1'b0;
        end
    end

endmodule

// File: rtl/vadd_multi_ctrl.sv
// Batch sequencer for the vector-add accelerator: runs NUM_LOAD loads, then
// compute, then store, iter_count times per start, gating FIFO strobes by phase.
module vadd_multi_ctrl
    import vadd_ctrl_pkg::*;
#(
    parameter int NUM_LOAD = 2,
    parameter int CNT_W    = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [CNT_W-1:0]    iter_count,
    output logic [CNT_W-1:0]    iter_idx,
    output logic [NUM_LOAD-1:0] ld_ap_start,
    input  logic [NUM_LOAD-1:0] ld_ap_done,
    input  logic [NUM_LOAD-1:0] ld_ap_ready,
    input  logic [NUM_LOAD-1:0] ld_strm_write,
    output logic [NUM_LOAD-1:0] in_fifo_write,
    output logic                cp_ap_start,
    input  logic                cp_ap_done,
    input  logic                cp_ap_ready,
    input  logic [NUM_LOAD-1:0] cp_strm_read,
    input  logic                cp_strm_write,
    output logic [NUM_LOAD-1:0] in_fifo_read,
    output logic                out_fifo_write,
    output logic                st_ap_start,
    input  logic                st_ap_done,
    input  logic                st_ap_ready,
    input  logic                st_strm_read,
    output logic                out_fifo_read
);

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]    count;
    logic [NUM_LOAD-1:0] ld_seen;
    logic                ld_set;
    logic                cp_set;
    logic                st_set;
    logic                accept;
    logic                advance;
    logic                last_iter;
    logic                loads_done;

    assign last_iter  = (iter_idx == count - CNT_W'(1));
    assign loads_done = &(ld_seen | ld_ap_done);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ld_set     = 1'b0;
        cp_set     = 1'b0;
        st_set     = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        ap_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    accept = 1'b1;
                    if (iter_count == '0) begin
                        next_state = S_ZERO;
                    end else begin
                        ld_set     = 1'b1;
                        next_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (loads_done) begin
                    next_state = S_CP_ISSUE;
                end
            end
            S_CP_ISSUE: begin
                cp_set     = 1'b1;
                next_state = S_CP_WAIT;
            end
            S_CP_WAIT: begin
                if (cp_ap_done) begin
                    next_state = S_ST_ISSUE;
                end
            end
            S_ST_ISSUE: begin
                st_set     = 1'b1;
                next_state = S_ST_WAIT;
            end
            S_ST_WAIT: begin
                if (st_ap_done) begin
                    if (last_iter) begin
                        ap_done    = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        advance    = 1'b1;
                        ld_set     = 1'b1;
                        next_state = S_LOAD;
                    end
                end
            end
            S_ZERO: begin
                ap_done    = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Count is captured only on acceptance, so later iter_count changes are ignored
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            count    <= '0;
            iter_idx <= '0;
        end else if (accept) begin
            count    <= iter_count;
            iter_idx <= '0;
        end else if (advance) begin
            iter_idx <= iter_idx + CNT_W'(1);
        end
    end

    // Load dones may land in different cycles; remember each until all are in
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ld_seen <= '0;
        end else if (ld_set) begin
            ld_seen <= '0;
        end else if (state[LOAD_IDX]) begin
            ld_seen <= ld_seen | ld_ap_done;
        end
    end

    for (genvar i = 0; i < NUM_LOAD; i++) begin : g_ld_start
        hls_start_reg u_ld_start (
            .ap_clk   (ap_clk),
            .ap_rst   (ap_rst),
            .set      (ld_set),
            .ap_ready (ld_ap_ready[i]),
            .ap_start (ld_ap_start[i])
        );
    end

    hls_start_reg u_cp_start (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .set      (cp_set),
        .ap_ready (cp_ap_ready),
        .ap_start (cp_ap_start)
    );

    hls_start_reg u_st_start (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .set      (st_set),
        .ap_ready (st_ap_ready),
        .ap_start (st_ap_start)
    );

    assign ap_ready       = ap_done;
    assign ap_idle        = state[IDLE_IDX] & ~ap_start;
    assign in_fifo_write  = ld_strm_write & {NUM_LOAD{state[LOAD_IDX]}};
    assign in_fifo_read   = cp_strm_read & {NUM_LOAD{state[CP_WAIT_IDX]}};
    assign out_fifo_write = cp_strm_write & state[CP_WAIT_IDX];
    assign out_fifo_read  = st_strm_read & state[ST_WAIT_IDX];

endmodule

// File: tb/tb_vadd_multi_ctrl.sv
// Directed bench for vadd_multi_ctrl: reset, single/skewed/multi batch runs,
// zero count, strobe gating and asynchronous reset mid-run.
module tb_vadd_multi_ctrl;

    localparam int NUM_LOAD = 2;
    localparam int CNT_W    = 16;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic                ap_start;
    logic                ap_done;
    logic                ap_idle;
    logic                ap_ready;
    logic [CNT_W-1:0]    iter_count;
    logic [CNT_W-1:0]    iter_idx;
    logic [NUM_LOAD-1:0] ld_ap_start;
    logic [NUM_LOAD-1:0] ld_ap_done;
    logic [NUM_LOAD-1:0] ld_ap_ready;
    logic [NUM_LOAD-1:0] ld_strm_write;
    logic [NUM_LOAD-1:0] in_fifo_write;
    logic                cp_ap_start;
    logic                cp_ap_done;
    logic                cp_ap_ready;
    logic [NUM_LOAD-1:0] cp_strm_read;
    logic                cp_strm_write;
    logic [NUM_LOAD-1:0] in_fifo_read;
    logic                out_fifo_write;
    logic                st_ap_start;
    logic                st_ap_done;
    logic                st_ap_ready;
    logic                st_strm_read;
    logic                out_fifo_read;

    int passed = 0;
    int total  = 0;
    int done_cnt    = 0;
    int ld_rise_cnt = 0;
    int start_cnt   = 0;
    logic prev_ld0 = 1'b0;

    vadd_multi_ctrl #(.NUM_LOAD(NUM_LOAD), .CNT_W(CNT_W)) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .iter_count     (iter_count),
        .iter_idx       (iter_idx),
        .ld_ap_start    (ld_ap_start),
        .ld_ap_done     (ld_ap_done),
        .ld_ap_ready    (ld_ap_ready),
        .ld_strm_write  (ld_strm_write),
        .in_fifo_write  (in_fifo_write),
        .cp_ap_start    (cp_ap_start),
        .cp_ap_done     (cp_ap_done),
        .cp_ap_ready    (cp_ap_ready),
        .cp_strm_read   (cp_strm_read),
        .cp_strm_write  (cp_strm_write),
        .in_fifo_read   (in_fifo_read),
        .out_fifo_write (out_fifo_write),
        .st_ap_start    (st_ap_start),
        .st_ap_done     (st_ap_done),
        .st_ap_ready    (st_ap_ready),
        .st_strm_read   (st_strm_read),
        .out_fifo_read  (out_fifo_read)
    );

    always #5 ap_clk = ~ap_clk;

    // Event counters sampled mid-cycle, away from the rising edge
    always @(negedge ap_clk) begin
        prev_ld0 <= ld_ap_start[0];
        if (ap_done) done_cnt <= done_cnt + 1;
        if (ld_ap_start[0] && !prev_ld0) ld_rise_cnt <= ld_rise_cnt + 1;
        if ((|ld_ap_start) || cp_ap_start || st_ap_start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one batch starting in its first LOAD cycle; load i finishes in LOAD cycle d_i
    task automatic run_batch(input int d0, input int d1, input logic [CNT_W-1:0] exp_idx,
                             input bit last);
        int dmax;
        dmax = (d0 > d1) ? d0 : d1;
        for (int c = 0; c <= dmax; c++) begin
            ld_ap_ready   = (c == 0) ? 2'b11 : 2'b00;
            ld_ap_done[0] = (c == d0);
            ld_ap_done[1] = (c == d1);
            ld_strm_write = 2'b11;
            cp_strm_read  = 2'b11;
            #1;
            check("load_in_fifo_write", in_fifo_write, 2'b11);
            check("load_in_fifo_read", in_fifo_read, 2'b00);
            check("load_ld_start", ld_ap_start, (c == 0) ? 2'b11 : 2'b00);
            if (c == 0) check("load_iter_idx", iter_idx, exp_idx);
            tick();
        end
        ld_ap_done  = '0;
        ld_ap_ready = '0;
        #1;
        check("cpissue_in_fifo_write", in_fifo_write, 2'b00);
        check("cpissue_in_fifo_read", in_fifo_read, 2'b00);
        check("cpissue_cp_start", cp_ap_start, 1'b0);
        tick();
        cp_strm_write = 1'b1;
        cp_ap_ready   = 1'b1;
        #1;
        check("cpwait_cp_start", cp_ap_start, 1'b1);
        check("cpwait_in_fifo_read", in_fifo_read, 2'b11);
        check("cpwait_out_fifo_write", out_fifo_write, 1'b1);
        tick();
        cp_ap_ready = 1'b0;
        #1;
        check("cpwait_cp_start_clr", cp_ap_start, 1'b0);
        tick();
        cp_ap_done = 1'b1;
        tick();
        cp_ap_done = 1'b0;
        #1;
        check("stissue_in_fifo_read", in_fifo_read, 2'b00);
        check("stissue_out_fifo_write", out_fifo_write, 1'b0);
        check("stissue_st_start", st_ap_start, 1'b0);
        ld_strm_write = '0;
        cp_strm_read  = '0;
        cp_strm_write = 1'b0;
        tick();
        st_ap_ready  = 1'b1;
        st_strm_read = 1'b1;
        #1;
        check("stwait_st_start", st_ap_start, 1'b1);
        check("stwait_out_fifo_read", out_fifo_read, 1'b1);
        check("stwait_no_done", ap_done, 1'b0);
        tick();
        st_ap_ready  = 1'b0;
        st_strm_read = 1'b0;
        st_ap_done   = 1'b1;
        #1;
        check("stwait_st_start_clr", st_ap_start, 1'b0);
        check("stdone_ap_done", ap_done, last);
        check("stdone_ap_ready", ap_ready, last);
        tick();
        st_ap_done = 1'b0;
        #1;
        check("after_batch_ap_done", ap_done, 1'b0);
        if (last) check("after_last_idle", ap_idle, 1'b1);
        else check("next_batch_ld_start", ld_ap_start, 2'b11);
    endtask

    initial begin
        int d_snap;
        int r_snap;
        int s_snap;
        ap_rst = 1'b1; ap_start = 1'b0; iter_count = '0;
        ld_ap_done = '0; ld_ap_ready = '0; ld_strm_write = '0;
        cp_ap_done = 1'b0; cp_ap_ready = 1'b0; cp_strm_read = '0; cp_strm_write = 1'b0;
        st_ap_done = 1'b0; st_ap_ready = 1'b0; st_strm_read = 1'b0;
        tick();
        tick();
        ap_rst = 1'b0;

        $display("[TB] reset state with raw strobes high in IDLE");
        ld_strm_write = 2'b11; cp_strm_read = 2'b11; cp_strm_write = 1'b1; st_strm_read = 1'b1;
        #1;
        check("rst_ap_idle", ap_idle, 1'b1);
        check("rst_ap_done", ap_done, 1'b0);
        check("rst_ap_ready", ap_ready, 1'b0);
        check("rst_ld_start", ld_ap_start, 2'b00);
        check("rst_cp_start", cp_ap_start, 1'b0);
        check("rst_st_start", st_ap_start, 1'b0);
        check("rst_iter_idx", iter_idx, 16'd0);
        check("rst_in_fifo_write", in_fifo_write, 2'b00);
        check("rst_in_fifo_read", in_fifo_read, 2'b00);
        check("rst_out_fifo_write", out_fifo_write, 1'b0);
        check("rst_out_fifo_read", out_fifo_read, 1'b0);
        ld_strm_write = '0; cp_strm_read = '0; cp_strm_write = 1'b0; st_strm_read = 1'b0;
        tick();

        $display("[TB] single batch, simultaneous load dones");
        d_snap = done_cnt;
        iter_count = 16'd1;
        ap_start   = 1'b1;
        #1;
        check("start_ap_idle_low", ap_idle, 1'b0);
        tick();
        ap_start = 1'b0;
        run_batch(0, 0, 16'd0, 1'b1);
        check("single_done_pulses", done_cnt - d_snap, 1);

        $display("[TB] single batch, skewed load dones");
        iter_count = 16'd1;
        ap_start   = 1'b1;
        tick();
        ap_start = 1'b0;
        run_batch(2, 7, 16'd0, 1'b1);

        $display("[TB] three batches, iter_count scribbled after acceptance");
        d_snap = done_cnt;
        r_snap = ld_rise_cnt;
        iter_count = 16'd3;
        ap_start   = 1'b1;
        tick();
        ap_start   = 1'b0;
        iter_count = 16'd0;
        run_batch(0, 0, 16'd0, 1'b0);
        run_batch(3, 1, 16'd1, 1'b0);
        run_batch(0, 2, 16'd2, 1'b1);
        check("three_ld_start_rises", ld_rise_cnt - r_snap, 3);
        check("three_done_pulses", done_cnt - d_snap, 1);

        $display("[TB] zero count");
        d_snap = done_cnt;
        s_snap = start_cnt;
        iter_count = 16'd0;
        ap_start   = 1'b1;
        tick();
        ap_start = 1'b0;
        #1;
        check("zero_ap_done", ap_done, 1'b1);
        check("zero_ap_ready", ap_ready, 1'b1);
        tick();
        check("zero_done_clear", ap_done, 1'b0);
        check("zero_back_idle", ap_idle, 1'b1);
        check("zero_done_pulses", done_cnt - d_snap, 1);
        check("zero_no_starts", start_cnt - s_snap, 0);

        $display("[TB] asynchronous reset during second batch LOAD");
        iter_count = 16'd5;
        ap_start   = 1'b1;
        tick();
        ap_start = 1'b0;
        run_batch(1, 0, 16'd0, 1'b0);
        check("midrun_iter_idx", iter_idx, 16'd1);
        #2;
        ap_rst = 1'b1;
        #1;
        check("arst_ld_start", ld_ap_start, 2'b00);
        check("arst_cp_start", cp_ap_start, 1'b0);
        check("arst_st_start", st_ap_start, 1'b0);
        check("arst_ap_idle", ap_idle, 1'b1);
        check("arst_iter_idx", iter_idx, 16'd0);
        tick();
        ap_rst = 1'b0;
        tick();
        check("post_rst_idle", ap_idle, 1'b1);
        check("post_rst_ld_start", ld_ap_start, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
